pipe_stage_skid: RTL and testbench

//  Generic inter-stage pipeline register (IF/ID, ID/EX, ...) carrying pc, pc+4 and instr.

---
 rtl/pipe_stage_skid_if.sv | 15 +
 rtl/pipe_stage_skid.sv | 121 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_if.sv
// Beat channel between pipeline stages: valid/ready handshake carrying pc, pc+4 and instr.
// The master drives the beat and the slave returns ready.
interface pipe_stage_skid_if #(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 32
) ();
  logic               valid;
  logic               ready;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_4;
  logic [INSTR_W-1:0] instr;

  modport master (output valid, output pc, output pc_4, output instr, input ready);
  modport slave  (input valid, input pc, input pc_4, input instr, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, synchronous flush and an
// optional 2-entry skid buffer that makes up.ready a register output.
module pipe_stage_skid #(
  parameter int unsigned        PC_W    = 32,
  parameter int unsigned        INSTR_W = 32,
  parameter bit                 SKID    = 1'b1,
  parameter logic [INSTR_W-1:0] BUBBLE  = '0
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst_n,
  pipe_stage_skid_if.slave  up,
  pipe_stage_skid_if.master dn,
  input  logic              flush,
  output logic [1:0]        occ
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e             state_q;
  logic               dn_valid_q;
  logic [PC_W-1:0]    dn_pc_q;
  logic [PC_W-1:0]    dn_pc_4_q;
  logic [INSTR_W-1:0] dn_instr_q;
  logic [PC_W-1:0]    skid_pc_q;
  logic [PC_W-1:0]    skid_pc_4_q;
  logic [INSTR_W-1:0] skid_instr_q;
  logic               up_ready_q;
  logic               up_ready;
  logic               acc;
  logic               con;

  // Without the skid entry a beat may only enter when the held one leaves this cycle.
  assign up_ready = SKID ? up_ready_q : (!dn_valid_q || dn.ready);
  assign acc      = up.valid & up_ready;
  assign con      = dn_valid_q & dn.ready;

  assign up.ready = up_ready;
  assign dn.valid = dn_valid_q;
  assign dn.pc    = dn_pc_q;
  assign dn.pc_4  = dn_pc_4_q;
  assign dn.instr = dn_instr_q;
  assign occ      = state_q;

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q      <= StEmpty;
      dn_valid_q   <= 1'b0;
      dn_pc_q      <= '0;
      dn_pc_4_q    <= '0;
      dn_instr_q   <= BUBBLE;
      skid_pc_q    <= '0;
      skid_pc_4_q  <= '0;
      skid_instr_q <= BUBBLE;
      up_ready_q   <= 1'b1;
    end else if (flush) begin
      state_q      <= StEmpty;
      dn_valid_q   <= 1'b0;
      dn_pc_q      <= '0;
      dn_pc_4_q    <= '0;
      dn_instr_q   <= BUBBLE;
      skid_pc_q    <= '0;
      skid_pc_4_q  <= '0;
      skid_instr_q <= BUBBLE;
      up_ready_q   <= 1'b1;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (acc) begin
            state_q    <= StOne;
            dn_valid_q <= 1'b1;
            dn_pc_q    <= up.pc;
            dn_pc_4_q  <= up.pc_4;
            dn_instr_q <= up.instr;
          end
        end
        StOne: begin
          if (acc && con) begin
            dn_pc_q    <= up.pc;
            dn_pc_4_q  <= up.pc_4;
            dn_instr_q <= up.instr;
          end else if (acc) begin
            // Consumer stalled: park the new beat and drop ready for the next cycle.
            state_q      <= StTwo;
            skid_pc_q    <= up.pc;
            skid_pc_4_q  <= up.pc_4;
            skid_instr_q <= up.instr;
            up_ready_q   <= 1'b0;
          end else if (con) begin
            state_q    <= StEmpty;
            dn_valid_q <= 1'b0;
            dn_pc_q    <= '0;
            dn_pc_4_q  <= '0;
            dn_instr_q <= BUBBLE;
          end
        end
        StTwo: begin
          if (con) begin
            state_q      <= StOne;
            dn_pc_q      <= skid_pc_q;
            dn_pc_4_q    <= skid_pc_4_q;
            dn_instr_q   <= skid_instr_q;
            skid_pc_q    <= '0;
            skid_pc_4_q  <= '0;
            skid_instr_q <= BUBBLE;
            up_ready_q   <= 1'b1;
          end
        end
        default: begin
          state_q    <= StEmpty;
          dn_valid_q <= 1'b0;
          up_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: one SKID=1 instance (u1/d1) and one SKID=0 instance
// (u0/d0); accepted beats are queued and popped whenever the consumer takes a beat.
module tb_pipe_stage_skid;
  localparam logic [31:0] BUBBLE = 32'h0000_0013;

  logic       clk;
  logic       rst_n;
  logic       flush1;
  logic       flush0;
  logic [1:0] occ1;
  logic [1:0] occ0;
  int         n_chk;
  int         n_err;

  logic [95:0] q1[$];
  logic [95:0] q0[$];

  pipe_stage_skid_if #(.PC_W(32), .INSTR_W(32)) u1 ();
  pipe_stage_skid_if #(.PC_W(32), .INSTR_W(32)) d1 ();
  pipe_stage_skid_if #(.PC_W(32), .INSTR_W(32)) u0 ();
  pipe_stage_skid_if #(.PC_W(32), .INSTR_W(32)) d0 ();

  pipe_stage_skid #(.PC_W(32), .INSTR_W(32), .SKID(1'b1), .BUBBLE(BUBBLE)) dut1 (
    .cpu_clk   (clk),
    .cpu_rst_n (rst_n),
    .up        (u1),
    .dn        (d1),
    .flush     (flush1),
    .occ       (occ1)
  );

  pipe_stage_skid #(.PC_W(32), .INSTR_W(32), .SKID(1'b0), .BUBBLE(BUBBLE)) dut0 (
    .cpu_clk   (clk),
    .cpu_rst_n (rst_n),
    .up        (u0),
    .dn        (d0),
    .flush     (flush0),
    .occ       (occ0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive1(input logic v, input logic [31:0] pc);
    u1.valid = v;
    u1.pc    = pc;
    u1.pc_4  = pc + 32'd4;
    u1.instr = 32'hC0DE_0000 ^ pc;
  endtask

  task automatic drive0(input logic v, input logic [31:0] pc);
    u0.valid = v;
    u0.pc    = pc;
    u0.pc_4  = pc + 32'd4;
    u0.instr = 32'hC0DE_0000 ^ pc;
  endtask

  // Record accepted beats; a beat offered on a flush cycle is dropped.
  always @(negedge clk) begin
    if (rst_n && !flush1 && u1.valid && u1.ready) q1.push_back({u1.pc, u1.pc_4, u1.instr});
    if (rst_n && !flush0 && u0.valid && u0.ready) q0.push_back({u0.pc, u0.pc_4, u0.instr});
  end

  always @(posedge clk) begin
    if (flush1) q1.delete();
    if (flush0) q0.delete();
  end

  always @(negedge clk) begin : mon1
    logic [95:0] b;
    if (rst_n) begin
      if (d1.valid && d1.ready) begin
        if (q1.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL skid_unexpected_beat: got pc %0h expected none", d1.pc);
        end else begin
          b = q1.pop_front();
          chk("skid_pc", {32'd0, d1.pc}, {32'd0, b[95:64]});
          chk("skid_pc_4", {32'd0, d1.pc_4}, {32'd0, b[63:32]});
          chk("skid_instr", {32'd0, d1.instr}, {32'd0, b[31:0]});
        end
      end else if (!d1.valid) begin
        chk("skid_bubble_instr", {32'd0, d1.instr}, {32'd0, BUBBLE});
        chk("skid_bubble_pcs", {d1.pc, d1.pc_4}, 64'd0);
      end
    end
  end

  always @(negedge clk) begin : mon0
    logic [95:0] b;
    if (rst_n) begin
      if (d0.valid && d0.ready) begin
        if (q0.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL noskid_unexpected_beat: got pc %0h expected none", d0.pc);
        end else begin
          b = q0.pop_front();
          chk("noskid_pc", {32'd0, d0.pc}, {32'd0, b[95:64]});
          chk("noskid_pc_4", {32'd0, d0.pc_4}, {32'd0, b[63:32]});
          chk("noskid_instr", {32'd0, d0.instr}, {32'd0, b[31:0]});
        end
      end else if (!d0.valid) begin
        chk("noskid_bubble_instr", {32'd0, d0.instr}, {32'd0, BUBBLE});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    flush1 = 1'b0;
    flush0 = 1'b0;
    d1.ready = 1'b1;
    d0.ready = 1'b1;
    drive0(1'b0, 32'h0);
    // 1: reset with a beat offered
    drive1(1'b1, 32'h100);
    repeat (2) tick();
    smp();
    chk("rst_occ", {62'd0, occ1}, 64'd0);
    chk("rst_dn_valid", {63'd0, d1.valid}, 64'd0);
    chk("rst_dn_instr", {32'd0, d1.instr}, {32'd0, BUBBLE});
    chk("rst_up_ready", {63'd0, u1.ready}, 64'd1);
    chk("rst_noskid_occ", {62'd0, occ0}, 64'd0);
    tick();
    drive1(1'b0, 32'h0);
    rst_n = 1'b1;

    // 2: back-to-back stream, one-cycle latency, no gaps
    drive1(1'b1, 32'h0);
    tick();
    drive1(1'b1, 32'h4);
    smp();
    chk("stream_pc0", {32'd0, d1.pc}, 64'h0);
    chk("stream_occ0", {62'd0, occ1}, 64'd1);
    tick();
    drive1(1'b1, 32'h8);
    smp();
    chk("stream_pc4", {32'd0, d1.pc}, 64'h4);
    chk("stream_occ1", {62'd0, occ1}, 64'd1);
    tick();
    drive1(1'b0, 32'h0);
    smp();
    chk("stream_pc8", {32'd0, d1.pc}, 64'h8);
    chk("stream_valid8", {63'd0, d1.valid}, 64'd1);
    tick();
    smp();
    chk("stream_drained", {62'd0, occ1}, 64'd0);

    // 3: stall fills skid, then drains in order
    tick();
    d1.ready = 1'b0;
    drive1(1'b1, 32'h0);
    tick();
    drive1(1'b1, 32'h4);
    smp();
    chk("stall_ready_one", {63'd0, u1.ready}, 64'd1);
    tick();
    drive1(1'b0, 32'h0);
    smp();
    chk("stall_occ2", {62'd0, occ1}, 64'd2);
    chk("stall_ready_low", {63'd0, u1.ready}, 64'd0);
    chk("stall_pc_held", {32'd0, d1.pc}, 64'h0);
    tick();
    smp();
    chk("stall_pc_still", {32'd0, d1.pc}, 64'h0);
    tick();
    d1.ready = 1'b1;
    smp();
    chk("drain_pc0", {32'd0, d1.pc}, 64'h0);
    tick();
    smp();
    chk("drain_pc4", {32'd0, d1.pc}, 64'h4);
    chk("drain_ready", {63'd0, u1.ready}, 64'd1);
    chk("drain_occ1", {62'd0, occ1}, 64'd1);
    tick();
    smp();
    chk("drain_occ0", {62'd0, occ1}, 64'd0);

    // 4: flush at occ=2 with a beat offered
    tick();
    d1.ready = 1'b0;
    drive1(1'b1, 32'h10);
    tick();
    drive1(1'b1, 32'h14);
    tick();
    drive1(1'b1, 32'hC);
    flush1 = 1'b1;
    smp();
    chk("flush_pre_occ", {62'd0, occ1}, 64'd2);
    tick();
    flush1 = 1'b0;
    drive1(1'b0, 32'h0);
    d1.ready = 1'b1;
    smp();
    chk("flush_occ", {62'd0, occ1}, 64'd0);
    chk("flush_valid", {63'd0, d1.valid}, 64'd0);
    chk("flush_instr", {32'd0, d1.instr}, {32'd0, BUBBLE});
    chk("flush_ready", {63'd0, u1.ready}, 64'd1);
    repeat (2) tick();

    // flush at occ=1: consumed beat counts, offered beat dropped despite ready=1
    drive1(1'b1, 32'h18);
    tick();
    drive1(1'b1, 32'h20);
    flush1 = 1'b1;
    smp();
    chk("flush1_ready_hi", {63'd0, u1.ready}, 64'd1);
    tick();
    flush1 = 1'b0;
    drive1(1'b0, 32'h0);
    smp();
    chk("flush1_occ", {62'd0, occ1}, 64'd0);
    repeat (2) tick();

    // 5: SKID=0 combinational ready and replace
    d0.ready = 1'b0;
    drive0(1'b1, 32'h50);
    smp();
    chk("noskid_ready_empty", {63'd0, u0.ready}, 64'd1);
    tick();
    drive0(1'b1, 32'h54);
    smp();
    chk("noskid_ready_stall", {63'd0, u0.ready}, 64'd0);
    chk("noskid_occ_held", {62'd0, occ0}, 64'd1);
    chk("noskid_pc_held", {32'd0, d0.pc}, 64'h50);
    tick();
    d0.ready = 1'b1;
    smp();
    chk("noskid_ready_comb", {63'd0, u0.ready}, 64'd1);
    tick();
    drive0(1'b0, 32'h0);
    smp();
    chk("noskid_replace_pc", {32'd0, d0.pc}, 64'h54);
    chk("noskid_replace_occ", {62'd0, occ0}, 64'd1);
    tick();
    smp();
    chk("noskid_drained", {62'd0, occ0}, 64'd0);

    // 6: async reset mid-stall, then a normal beat
    tick();
    d1.ready = 1'b0;
    drive1(1'b1, 32'h30);
    tick();
    drive1(1'b1, 32'h34);
    tick();
    drive1(1'b0, 32'h0);
    smp();
    chk("rst2_pre_occ", {62'd0, occ1}, 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst2_occ", {62'd0, occ1}, 64'd0);
    chk("rst2_valid", {63'd0, d1.valid}, 64'd0);
    chk("rst2_instr", {32'd0, d1.instr}, {32'd0, BUBBLE});
    chk("rst2_pc", {32'd0, d1.pc}, 64'h0);
    chk("rst2_ready", {63'd0, u1.ready}, 64'd1);
    q1.delete();
    q0.delete();
    tick();
    rst_n = 1'b1;
    d1.ready = 1'b1;
    drive1(1'b1, 32'h40);
    tick();
    drive1(1'b0, 32'h0);
    smp();
    chk("rst2_post_pc", {32'd0, d1.pc}, 64'h40);
    chk("rst2_post_occ", {62'd0, occ1}, 64'd1);
    tick();
    smp();
    chk("rst2_post_drain", {62'd0, occ1}, 64'd0);

    repeat (2) tick();
    chk("skid_queue_empty", 64'(q1.size()), 64'd0);
    chk("noskid_queue_empty", 64'(q0.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
